fetch_ctrl: RTL and testbench

//  Instruction-fetch controller that sequences the code ROM. Holds the PC and issues
//  one word read per cycle to the ROM (1-cycle registered read latency). Buffers

---
 rtl/fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch controller for the code ROM. Holds the PC, issues one
//   word read per cycle to a ROM with a 1-cycle registered read, buffers the
//   returned words in a 2-entry in-order FIFO and presents {inst, pc, fault}
//   to decode with a valid/ready handshake. Redirects flush everything in
//   flight and restart fetch. A misaligned or out-of-range PC produces a
//   single fault entry and parks the controller in HALT until a redirect.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   rom_addr_o     out  byte address to the ROM (current PC)
//   rom_data_i     in   ROM read data, valid one cycle after the address
//   redirect_i     in   flush and restart fetch at redirect_pc_i
//   redirect_pc_i  in   new PC for a redirect
//   inst_valid_o   out  FIFO head valid
//   inst_ready_i   in   decode accepts the head entry
//   inst_o         out  head instruction word (0 for a fault entry)
//   inst_pc_o      out  head PC
//   inst_fault_o   out  head entry is a fetch fault
//   halted_o       out  controller is in HALT
//
// State   | meaning
// --------+---------------------------------------------------------------
// RUN     | fetching sequentially from pc_q whenever the FIFO has room
// HALT    | fault entry queued; no fetches until redirect_i
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int                     ADDR_WIDTH = 64,
  parameter int                     DATA_WIDTH = 32,
  parameter int                     ROM_SIZE   = 12,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_fault_o,
  output logic                  halted_o
);

  // First byte address past the end of the ROM.
  localparam logic [ADDR_WIDTH-1:0] ROM_BYTES = ADDR_WIDTH'(1) << (ROM_SIZE + 2);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fault;
  } entry_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic                  inflight_q;
  logic                  valid_q;
  logic                  halted_q;

  // slot_q[0] is the head. Slots at or beyond count_q are kept at zero so the
  // head fields read as zero whenever the FIFO is empty.
  entry_t                slot_q [2];
  logic [1:0]            count_q;
  entry_t                slot_d [2];
  logic [1:0]            count_d;

  logic                  pop;
  logic [2:0]            occupancy;
  logic                  space;
  logic                  pc_legal;
  logic                  issue;
  logic                  fault_push;
  logic                  resp_push;

  assign rom_addr_o   = pc_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = slot_q[0].inst;
  assign inst_pc_o    = slot_q[0].pc;
  assign inst_fault_o = slot_q[0].fault;
  assign halted_o     = halted_q;

  assign pop        = valid_q & inst_ready_i;
  // Outstanding ROM reads count against capacity, so count_q + inflight_q
  // never exceeds 2 and the FIFO cannot overflow.
  assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
  assign space      = (occupancy < 3'd2) | pop;
  assign pc_legal   = (pc_q[1:0] == 2'b00) && (pc_q < ROM_BYTES);
  assign issue      = (state_q == RUN) & space & pc_legal & ~redirect_i;
  assign fault_push = (state_q == RUN) & space & ~pc_legal & ~redirect_i;
  assign resp_push  = inflight_q & ~redirect_i;

  // Next FIFO contents. A response and a fault can land in the same cycle
  // (last legal word returning while the PC has just stepped past the end);
  // the response is older, so it is written first.
  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (pop) begin
      slot_d[0] = slot_q[1];
      slot_d[1] = '0;
      count_d   = count_q - 2'd1;
    end
    if (resp_push) begin
      slot_d[count_d[0]] = '{inst: rom_data_i, pc: inflight_pc_q, fault: 1'b0};
      count_d            = count_d + 2'd1;
    end
    if (fault_push) begin
      slot_d[count_d[0]] = '{inst: '0, pc: pc_q, fault: 1'b1};
      count_d            = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      valid_q       <= 1'b0;
      halted_q      <= 1'b0;
      slot_q        <= '{default: '0};
      count_q       <= 2'd0;
    end else if (redirect_i) begin
      // The ROM response for any outstanding read is dropped next cycle
      // because inflight_q is cleared here.
      state_q       <= RUN;
      pc_q          <= redirect_pc_i;
      inflight_q    <= 1'b0;
      valid_q       <= 1'b0;
      halted_q      <= 1'b0;
      slot_q        <= '{default: '0};
      count_q       <= 2'd0;
    end else begin
      slot_q     <= slot_d;
      count_q    <= count_d;
      valid_q    <= (count_d != 2'd0);
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + ADDR_WIDTH'(4);
      end
      if (fault_push) begin
        state_q  <= HALT;
        halted_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [63:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  fetch_ctrl #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (32),
    .ROM_SIZE   (12),
    .RESET_PC   (64'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (inst_ready),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_fault_o  (inst_fault),
    .halted_o      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word i holds i + 0x100, one-cycle registered read.
  always @(posedge clk) rom_data <= 32'h100 + {20'd0, rom_addr[13:2]};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Asserts reset, checks the reset values, releases at a falling edge so the
  // caller resumes in cycle 0.
  task automatic do_reset(input string tag);
    rst        = 1'b1;
    redirect   = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    #1;
    chk({tag, " rst valid"}, 64'(inst_valid), 64'd0);
    chk({tag, " rst inst"},  64'(inst), 64'd0);
    chk({tag, " rst pc"},    inst_pc, 64'd0);
    chk({tag, " rst fault"}, 64'(inst_fault), 64'd0);
    chk({tag, " rst halted"}, 64'(halted), 64'd0);
    chk({tag, " rst rom_addr"}, rom_addr, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rs;
    bit          rdy;
    bit          rd;
    logic [63:0] rpc;
    bit          ev;
    logic [63:0] epc;
    logic [31:0] einst;
    bit          ef;
    bit          eh;
  } vec_t;

  function automatic vec_t mk(bit rs, bit rdy, bit rd, logic [63:0] rpc,
                              bit ev, logic [63:0] epc, logic [31:0] ei, bit ef, bit eh);
    vec_t v;
    v.rs = rs; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.einst = ei; v.ef = ef; v.eh = eh;
    return v;
  endfunction

  vec_t vecs[$];

  logic [63:0] s5_pc   [5] = '{64'h3FF0, 64'h3FF4, 64'h3FF8, 64'h3FFC, 64'h4000};
  logic [31:0] s5_inst [5] = '{32'h10FC, 32'h10FD, 32'h10FE, 32'h10FF, 32'h0};
  logic        s5_flt  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;

    //                rs rdy rd rpc      ev epc      inst      f  h
    // Sequential fetch from reset, ready always high.
    vecs.push_back(mk(1, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 0)); // c0
    vecs.push_back(mk(0, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h0,  32'h100, 0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h4,  32'h101, 0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h8,  32'h102, 0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'hC,  32'h103, 0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h10, 32'h104, 0, 0));
    // Backpressure: ready low for 5 cycles from the first valid.
    vecs.push_back(mk(1, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 0)); // c0
    vecs.push_back(mk(0, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,  1, 64'h0,  32'h100, 0, 0)); // c2
    vecs.push_back(mk(0, 0, 0, 64'h0,  1, 64'h0,  32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,  1, 64'h0,  32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,  1, 64'h0,  32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,  1, 64'h0,  32'h100, 0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h0,  32'h100, 0, 0)); // c7
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h4,  32'h101, 0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h8,  32'h102, 0, 0));
    // Redirect in steady state (one buffered + one in flight).
    vecs.push_back(mk(0, 1, 1, 64'h40, 1, 64'hC,  32'h103, 0, 0)); // c10
    vecs.push_back(mk(0, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h40, 32'h110, 0, 0)); // c13
    // Fill the FIFO, then redirect with two entries buffered.
    vecs.push_back(mk(0, 0, 0, 64'h0,  1, 64'h44, 32'h111, 0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h80, 1, 64'h44, 32'h111, 0, 0)); // c15
    vecs.push_back(mk(0, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h80, 32'h120, 0, 0)); // c18
    // Misaligned redirect -> single fault entry, HALT, then resume.
    vecs.push_back(mk(0, 1, 1, 64'h42, 1, 64'h84, 32'h121, 0, 0)); // c19
    vecs.push_back(mk(0, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h42, 32'h0,   1, 1)); // c21
    vecs.push_back(mk(0, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 1));
    vecs.push_back(mk(0, 1, 1, 64'h10, 0, 64'h0,  32'h0,   0, 1)); // c23
    vecs.push_back(mk(0, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  0, 64'h0,  32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h10, 32'h104, 0, 0)); // c26
    vecs.push_back(mk(0, 1, 0, 64'h0,  1, 64'h14, 32'h105, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rs) do_reset($sformatf("v%0d", i));
      inst_ready  = vecs[i].rdy;
      redirect    = vecs[i].rd;
      redirect_pc = vecs[i].rpc;
      chk($sformatf("v%0d valid", i), 64'(inst_valid), 64'(vecs[i].ev));
      chk($sformatf("v%0d halted", i), 64'(halted), 64'(vecs[i].eh));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d pc", i), inst_pc, vecs[i].epc);
        chk($sformatf("v%0d inst", i), 64'(inst), 64'(vecs[i].einst));
        chk($sformatf("v%0d fault", i), 64'(inst_fault), 64'(vecs[i].ef));
      end
      step();
    end

    // Run off the end of the ROM: last four words then a fault at 0x4000.
    begin
      int k;
      k = 0;
      inst_ready  = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 64'h3FF0;
      step();
      redirect = 1'b0;
      for (int c = 0; c < 20 && k < 5; c++) begin
        if (inst_valid) begin
          chk($sformatf("end%0d pc", k), inst_pc, s5_pc[k]);
          chk($sformatf("end%0d inst", k), 64'(inst), 64'(s5_inst[k]));
          chk($sformatf("end%0d fault", k), 64'(inst_fault), 64'(s5_flt[k]));
          k++;
          if (k == 5) chk("end halted", 64'(halted), 64'd1);
        end
        step();
      end
      n_cmp++;
      if (k != 5) begin
        n_err++;
        $display("FAIL end timeout: got %0d entries expected 5", k);
      end
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("end idle%0d valid", c), 64'(inst_valid), 64'd0);
        step();
      end
    end

    // Reset mid-stream, then restart from RESET_PC.
    redirect    = 1'b1;
    redirect_pc = 64'h0;
    step();
    redirect = 1'b0;
    step(); step(); step();
    chk("pre-rst valid", 64'(inst_valid), 64'd1);
    #2;
    do_reset("mid");
    inst_ready = 1'b1;
    step();
    chk("restart c1 valid", 64'(inst_valid), 64'd0);
    step();
    chk("restart c2 valid", 64'(inst_valid), 64'd1);
    chk("restart c2 pc", inst_pc, 64'h0);
    chk("restart c2 inst", 64'(inst), 64'h100);
    step();
    chk("restart c3 valid", 64'(inst_valid), 64'd1);
    chk("restart c3 pc", inst_pc, 64'h4);
    chk("restart c3 inst", 64'(inst), 64'h101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
